sync_ram_wr: RTL and testbench
==============================

Name: sync_ram_wr

Overview:
- Writable, synchronous counterpart to the team's combinational lookup ROMs.
- Lookup tables, such as the 3-bit {a,b,cin} -> 2-bit {cout,sum} adder table, are loaded at run time through a valid/ready write port, not fixed at elaboration.
- Reads are registered with one-cycle latency.
- A built-in init sweep clears every word to INIT_VAL after reset or on request, so contents are never X.

Parameters:
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- DATA_W, 2, word width.
- INIT_VAL, '0, value written to every word during the init sweep.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  single-cycle pulse; restarts the init sweep.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted when rd_valid & rd_ready.
- rd_addr  in  ADDR_W  read address.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  DATA_W  read result.
- init_done  out  1  high once the sweep has completed.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to INIT with init_cnt=0.
  - Outputs: wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0, init_done=0.
  - The storage array itself has no reset; it is cleared only by the sweep.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle writes mem[init_cnt]=INIT_VAL, then init_cnt++.
  - After writing the word at init_cnt = 2**ADDR_W-1, the next state is RUN. The sweep lasts exactly 2**ADDR_W cycles.
  - init_done rises on the first RUN cycle.
  - wr_ready=0 and rd_ready=0 throughout INIT.
- RUN:
  - wr_ready=1 and rd_ready=1, driven combinationally from state only (no dependency on valid).
  - Accepted write: mem[wr_addr] <= wr_data at the same edge.
  - Accepted read: rsp_data <= mem[rd_addr] and rsp_valid <= 1 at the same edge. Latency is exactly 1 cycle.
  - No read that cycle: rsp_valid <= 0 and rsp_data holds its last value.
  - Back-to-back reads are accepted every cycle with full throughput.
  - The response path has no backpressure; the consumer must always take the response.
- Read and write to the same address in the same cycle: read-first. rsp_data returns the old word and the new word is visible to reads from the next cycle.
- clr:
  - In RUN: next state INIT, init_cnt=0, init_done=0.
  - A read accepted in the same cycle as clr still produces its response next cycle, holding pre-clear data.
  - A write accepted in the same cycle as clr is performed but then overwritten by the sweep.
  - During INIT: restarts the sweep from 0.
- Reset asserted mid-sweep or mid-read: immediate return to the reset state. Any pending rsp_valid is dropped.
- Widths: init_cnt is ADDR_W+1 bits, or ADDR_W bits with an explicit last-word compare. No wrap-around may re-enter INIT.
- Addresses are always in range because depth is a full power of two.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic {INIT, RUN} ram_state_e;
  - default constants ADDR_W_DEF=3 and DATA_W_DEF=2.
- One sub-module, ram_core: parameterised storage array with one write port and one registered read port (read-first), with no reset.
- The FSM, init counter and handshake logic live in the top-level sync_ram_wr.

Test Plan:
1. Reset then idle:
   - Release rst_n and hold all requests low.
   - Require: wr_ready=rd_ready=0 for 8 cycles, init_done=1 on cycle 9, then read addr 5 -> rsp_data=2'b00 one cycle later.
2. Load and read back the full-adder table:
   - Write 0:00, 1:01, 2:01, 3:10, 4:01, 5:10, 6:10, 7:11.
   - Read addresses 0..7 back-to-back.
   - Require: rsp_valid high for 8 consecutive cycles with data matching the table in order.
3. Same-address collision:
   - mem[3]=2'b10; in the same cycle write 3:2'b01 and read 3.
   - Require: rsp_data=2'b10. A following read of 3 returns 2'b01.
4. clr in RUN:
   - After test 2, pulse clr together with a read of addr 7.
   - Require: rsp_data=2'b11 next cycle, then init_done=0 and both readies 0 for 8 cycles.
   - After the sweep, read addr 7 -> 2'b00.
5. Reset mid-sweep:
   - Assert rst_n=0 at sweep cycle 4.
   - Require: all outputs at reset values immediately.
   - After release, the full 8-cycle sweep repeats before init_done=1.
6. Idle hold:
   - Read addr 6 (2'b10), then 5 idle cycles.
   - Require: rsp_valid=0 and rsp_data stays 2'b10 throughout.

Source files
------------

// File: rtl/sync_ram_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared state type and default geometry for the writable
//            synchronous lookup RAM.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_e;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 2;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/sync_ram_wr_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_ram_wr_if
// Brief    : Write / read / response bus of the lookup RAM. The master loads
//            tables and issues reads; the slave is the RAM itself.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_ram_wr_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              clr;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              init_done;

    modport master (
        output clr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rsp_valid, rsp_data, init_done
    );

    modport slave (
        input  clr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rsp_valid, rsp_data, init_done
    );

endinterface : sync_ram_wr_if
`default_nettype wire

// File: rtl/sync_ram_wr_ram_core.sv
`default_nettype none
// ============================================================================
// Module   : ram_core
// Brief    : Plain storage array, one write port and one registered
//            read-first read port. No reset: contents are owned by the
//            caller's init sweep, and the read register holds when idle.
// Revision : 1.0 - initial release
// ============================================================================
module ram_core #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic              re,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write and read share one edge; the read samples the old word (read-first).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : ram_core
`default_nettype wire

// File: rtl/sync_ram_wr.sv
`default_nettype none
// ============================================================================
// Module   : sync_ram_wr
// Brief    : Run-time loadable lookup RAM. Sweeps every word to INIT_VAL after
//            reset or clr, then serves valid/ready writes and reads with a
//            one-cycle registered read response.
// Revision : 1.0 - initial release
// ============================================================================
module sync_ram_wr
    import mem_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    sync_ram_wr_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    ram_state_e        state_q,     state_d;
    logic [ADDR_W-1:0] init_cnt_q,  init_cnt_d;
    logic              init_done_q, init_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    // Set by the first accepted read; until then rsp_data reads as zero
    // because the core's read register has no reset.
    logic              rd_seen_q,   rd_seen_d;

    logic              w_run;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_core_rdata;

    assign w_run     = (state_q == RUN);
    assign w_wr_fire = bus.wr_valid & w_run;
    assign w_rd_fire = bus.rd_valid & w_run;

    // The sweep owns the write port while initialising.
    assign w_mem_we    = !w_run | w_wr_fire;
    assign w_mem_waddr = w_run ? bus.wr_addr : init_cnt_q;
    assign w_mem_wdata = w_run ? bus.wr_data : INIT_VAL;

    ram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (w_mem_waddr),
        .wdata (w_mem_wdata),
        .re    (w_rd_fire),
        .raddr (bus.rd_addr),
        .rdata (w_core_rdata)
    );

    // Next-state: sweep counter, INIT/RUN transitions and response flags.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = w_rd_fire;
        rd_seen_d   = rd_seen_q | w_rd_fire;
        case (state_q)
            INIT: begin
                if (bus.clr) begin
                    init_cnt_d = '0;
                end else if (init_cnt_q == c_last_addr) begin
                    init_cnt_d  = '0;
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (bus.clr) begin
                    state_d     = INIT;
                    init_cnt_d  = '0;
                    init_done_d = 1'b0;
                end
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Control state registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rd_seen_q   <= rd_seen_d;
        end
    end

    assign bus.wr_ready  = w_run;
    assign bus.rd_ready  = w_run;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rd_seen_q ? w_core_rdata : '0;
    assign bus.init_done = init_done_q;

endmodule : sync_ram_wr
`default_nettype wire

// File: tb/tb_sync_ram_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_ram_wr
// Brief    : Self-checking bench for sync_ram_wr: directed scenarios followed
//            by random traffic, compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_ram_wr;

    localparam int SWEEP = 8;

    logic clk;
    logic rst_n;

    sync_ram_wr_if #(.ADDR_W(3), .DATA_W(2)) bus ();

    sync_ram_wr #(.ADDR_W(3), .DATA_W(2), .INIT_VAL(2'b00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: memory image, cycles left in the sweep, expected response.
    logic [1:0] ref_mem [8];
    int         init_left;
    logic       exp_rsp_valid;
    logic [1:0] exp_rsp_data;

    logic [1:0] fa_tbl [8];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic rdy;
        rdy = (init_left == 0);
        chk({tag, ".wr_ready"},  8'(bus.wr_ready),  8'(rdy));
        chk({tag, ".rd_ready"},  8'(bus.rd_ready),  8'(rdy));
        chk({tag, ".init_done"}, 8'(bus.init_done), 8'(rdy));
        chk({tag, ".rsp_valid"}, 8'(bus.rsp_valid), 8'(exp_rsp_valid));
        chk({tag, ".rsp_data"},  8'(bus.rsp_data),  8'(exp_rsp_data));
    endtask

    function automatic void model_clear();
        foreach (ref_mem[i]) ref_mem[i] = 2'b00;
    endfunction

    function automatic void model_reset();
        init_left     = SWEEP;
        exp_rsp_valid = 1'b0;
        exp_rsp_data  = 2'b00;
        model_clear();
    endfunction

    // One clock cycle with the given requests, then model update and check.
    task automatic cycle(input string tag, input logic c,
                         input logic wv, input logic [2:0] wa, input logic [1:0] wd,
                         input logic rv, input logic [2:0] ra);
        bus.clr      = c;
        bus.wr_valid = wv;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_valid = rv;
        bus.rd_addr  = ra;
        @(posedge clk);
        #1;
        if (init_left == 0) begin
            exp_rsp_valid = rv;
            if (rv) exp_rsp_data = ref_mem[ra];
            if (wv) ref_mem[wa] = wd;
            if (c) begin
                init_left = SWEEP;
                model_clear();
            end
        end else begin
            exp_rsp_valid = 1'b0;
            if (c) init_left = SWEEP;
            else   init_left--;
        end
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0);
    endtask

    task automatic rd(input string tag, input logic [2:0] a);
        cycle(tag, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, a);
    endtask

    task automatic wr(input string tag, input logic [2:0] a, input logic [1:0] d);
        cycle(tag, 1'b0, 1'b1, a, d, 1'b0, 3'd0);
    endtask

    initial begin
        fa_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst_n        = 1'b0;
        bus.clr      = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = '0;
        model_reset();

        // 1: reset, sweep with idle bus, then read a cleared word
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < SWEEP; i++) idle("sweep1");
        rd("rd5_cleared", 3'd5);
        chk("rd5_cleared.data_abs", 8'(bus.rsp_data), 8'h00);

        // 2: load full-adder table, read back-to-back
        for (int i = 0; i < 8; i++) wr("fa_wr", 3'(i), fa_tbl[i]);
        for (int i = 0; i < 8; i++) begin
            rd("fa_rd", 3'(i));
            chk("fa_rd.data_abs", 8'(bus.rsp_data), 8'(fa_tbl[i]));
        end

        // 3: same-address collision is read-first
        cycle("collide", 1'b0, 1'b1, 3'd3, 2'b01, 1'b1, 3'd3);
        chk("collide.old_abs", 8'(bus.rsp_data), 8'h02);
        rd("collide_after", 3'd3);
        chk("collide_after.new_abs", 8'(bus.rsp_data), 8'h01);
        wr("restore3", 3'd3, 2'b10);

        // 4: clr together with a read of addr 7
        cycle("clr_rd7", 1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 3'd7);
        chk("clr_rd7.data_abs", 8'(bus.rsp_data), 8'h03);
        for (int i = 0; i < SWEEP; i++) idle("sweep_clr");
        rd("rd7_cleared", 3'd7);
        chk("rd7_cleared.data_abs", 8'(bus.rsp_data), 8'h00);

        // 5a: reset mid-sweep (after 4 sweep cycles)
        cycle("clr_again", 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) idle("sweep_part");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs("rst_mid_sweep");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < SWEEP; i++) idle("sweep_after_rst");

        // 5b: reset with a response pending
        wr("pre_rst_wr", 3'd2, 2'b11);
        rd("pre_rst_rd", 3'd2);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs("rst_mid_read");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < SWEEP; i++) idle("sweep_after_rst2");

        // 6: read then hold while idle
        wr("wr6", 3'd6, 2'b10);
        rd("rd6", 3'd6);
        for (int i = 0; i < 5; i++) begin
            idle("hold");
            chk("hold.data_abs", 8'(bus.rsp_data), 8'h02);
        end

        // 7: random traffic including occasional clr
        for (int i = 0; i < 300; i++) begin
            cycle("rand",
                  ($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sync_ram_wr
`default_nettype wire
